// File: rtl/rv32_pkg.sv
// Shared RV32 constants used by the decoder, the datapath and the register file.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rv32_register_file.sv
// RV32I integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero with no backing storage.
module rv32_register_file
  import rv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  input  logic [REG_ADDR_W-1:0] A3,
  input  logic [XLEN-1:0]       WD3,
  input  logic                  WE3,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2
);

  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_wr_en;

  assign w_wr_en = WE3 && (A3 != ZERO_REG);

  // Storage update: reset outranks any pending write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[A3] <= WD3;
    end
  end

  // No write-to-read bypass: a read of A3 sees the old value until the edge.
  assign RD1 = (A1 == ZERO_REG) ? '0 : r_regs[A1];
  assign RD2 = (A2 == ZERO_REG) ? '0 : r_regs[A2];

endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench for rv32_register_file: directed scenarios followed by
// randomized traffic checked against an array-based reference model.
module tb_rv32_register_file;
  import rv32_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [REG_ADDR_W-1:0] A1, A2, A3;
  logic [XLEN-1:0]       WD3;
  logic                  WE3;
  logic [XLEN-1:0]       RD1, RD2;

  int n_pass  = 0;
  int n_total = 0;

  logic [XLEN-1:0] model [0:NREGS-1];

  rv32_register_file dut (
    .clk  (clk),
    .reset(reset),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WD3  (WD3),
    .WE3  (WE3),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] model_read(input logic [REG_ADDR_W-1:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // Compare both read ports against the reference model.
  task automatic check_reads(input string tag);
    #1;
    check({tag, "_rd1"}, RD1, model_read(A1));
    check({tag, "_rd2"}, RD2, model_read(A2));
  endtask

  // Advance one rising edge, applying the architectural update rules to the model.
  task automatic clock_step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    end else if (WE3 && A3 != 5'd0) begin
      model[A3] = WD3;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    reset = 1'b1; WE3 = 1'b1; A3 = 5'd1; WD3 = 32'd100; A1 = 5'd1; A2 = 5'd3;

    // 1: reset with pending write
    for (int i = 0; i < 5; i++) begin
      clock_step();
      check("rst_wr_rd1", RD1, 32'd0);
      check("rst_wr_rd2", RD2, 32'd0);
    end

    // 2: first write after reset; visible only after the edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("pre_edge_rd1", RD1, 32'd0);
    clock_step();
    check("post_edge_rd1", RD1, 32'd100);
    check("post_edge_rd2", RD2, 32'd0);

    // 3: hold with WE3 low
    @(negedge clk);
    WE3 = 1'b0; WD3 = 32'hDEADBEEF; A3 = 5'd1;
    for (int i = 0; i < 5; i++) begin
      clock_step();
      check("hold_rd1", RD1, 32'd100);
    end

    // 4: x0 never changes
    @(negedge clk);
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
    clock_step();
    check("x0_rd1", RD1, 32'd0);
    check("x0_rd2", RD2, 32'd0);
    @(negedge clk);
    WE3 = 1'b0;
    clock_step();
    check("x0_later_rd1", RD1, 32'd0);

    // 5: full sweep and paired reads
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      WE3 = 1'b1; A3 = 5'(i); WD3 = 32'(i) * 32'h01010101;
      clock_step();
    end
    @(negedge clk);
    WE3 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      check("sweep_rd1", RD1, 32'(i) * 32'h01010101);
      check("sweep_rd2", RD2, 32'(31 - i) * 32'h01010101);
    end
    A1 = 5'd7; A2 = 5'd7;
    #1;
    check("same_rd1", RD1, 32'h07070707);
    check("same_rd2", RD2, 32'h07070707);
    A1 = 5'd0;
    #1;
    check("sweep_x0", RD1, 32'd0);

    // 6: reset mid-operation beats a concurrent write
    @(negedge clk);
    reset = 1'b1; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h55;
    clock_step();
    @(negedge clk);
    reset = 1'b0; WE3 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      A1 = 5'(i); A2 = 5'(i);
      #1;
      check("mid_rst_rd1", RD1, 32'd0);
      check("mid_rst_rd2", RD2, 32'd0);
    end

    // Random traffic: check before each edge (old value) and after (new value)
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 49) == 0);
      WE3   = $urandom_range(0, 3) != 0;
      A3    = 5'($urandom_range(0, 31));
      WD3   = $urandom;
      A1    = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2    = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
      check_reads("rand_pre");
      clock_step();
      check_reads("rand_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
